game_status_ctrl: RTL and testbench
===================================

// Module: game_status_ctrl
// PURPOSE
//  Game-session controller for the HUD bar renderer: sequences MENU/PLAY/PAUSE/OVER,
//  counts hits (classic) or elapsed seconds (infinity), and drives the renderer's
//  enable_game_classic/enable_game_infinity/enable_information, HP_print and time_print.
//  Sits between the input debouncers and the VGA overlay; all outputs registered in clk.
// PARAMETERS
//  TICK_DIV      100_000_000  clk cycles per time_print step (1 s at 100 MHz)
//  HP_MAX        9            hits that end a classic game (9 x 20 px segments)
//  TIME_MAX      18           steps that end an infinity game (18 x 10 px segments)
//  GUARD_CYCLES  50_000_000   hit-ignore window after an accepted hit
// PORTS
//  clk                   in   1  system clock; sole clock domain
//  rst_n                 in   1  asynchronous active-low reset
//  mode                  in   3  3'd1 = classic, 3'd2 = infinity, else invalid; sampled on start
//  start                 in   1  1-cycle pulse, begins a game from MENU
//  hit                   in   1  1-cycle pulse, player damaged
//  pause                 in   1  1-cycle pulse, toggles PLAY <-> PAUSE
//  restart               in   1  1-cycle pulse, return to MENU from any state
//  enable_game_classic   out  1  high in classic PLAY/PAUSE/OVER
//  enable_game_infinity  out  1  high in infinity PLAY/PAUSE/OVER
//  enable_information    out  1  high in every state except MENU
//  HP_print              out  5  hits taken, 0..HP_MAX (bar shrinks as it grows)
//  time_print            out  5  elapsed steps, 0..TIME_MAX
//  game_over             out  1  high in OVER
// BEHAVIOUR
//  - Reset (async assert, sync release): state=MENU, all outputs 0, prescaler/guard 0.
//  - States: MENU, PLAY_C, PLAY_I, PAUSE, OVER; sess_mode reg (1b) remembers C/I.
//  - Priority each cycle: restart > start > pause > hit/tick.
//  - restart: any state -> MENU next edge; HP_print, time_print, prescaler, guard cleared.
//  - MENU: start & mode==1 -> PLAY_C; start & mode==2 -> PLAY_I; other mode -> stay MENU.
//    Entry into PLAY_x clears HP_print, time_print, prescaler, guard.
//  - PLAY_C: hit with guard==0 -> HP_print+1 next edge, guard loads GUARD_CYCLES-1.
//    guard!=0 -> hit ignored, guard decrements each cycle. If the accepted hit makes
//    HP_print==HP_MAX, state -> OVER on the same edge (game_over high with HP_print=HP_MAX).
//  - PLAY_I: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 wraps to 0 and time_print+1.
//    Step reaching TIME_MAX -> OVER on the same edge. hit ignored in PLAY_I.
//  - pause in PLAY_x -> PAUSE; pause in PAUSE -> PLAY_C/PLAY_I per sess_mode.
//    In PAUSE prescaler, guard, HP_print, time_print frozen; hit ignored; enables held.
//    pause and hit in the same PLAY_C cycle: pause wins, hit dropped.
//  - OVER: counters frozen; start, hit, pause ignored; only restart leaves.
//  - HP_print/time_print saturate at HP_MAX/TIME_MAX; never wrap.
//  - enable_game_classic = sess_mode==C && state!=MENU; infinity likewise; mutually exclusive.
//  - Output latency: 1 clk from input pulse to registered output change.
// TESTING (TICK_DIV=4, GUARD_CYCLES=3, HP_MAX=9, TIME_MAX=18)
//  1 reset mid-PLAY_C with HP_print=5 -> all outputs 0 immediately; MENU after release.
//  2 start,mode=1; 9 hits spaced 4 cycles -> HP_print 1..9, game_over=1 after 9th; 10th hit no change.
//  3 PLAY_C: hits on consecutive cycles c,c+1,c+2,c+3 -> only c and c+3 accepted, HP_print=2.
//  4 start,mode=2; run 72 cycles -> time_print=18, game_over=1, enable_game_infinity=1.
//  5 PLAY_I: pause at time_print=3 for 20 cycles, pause again -> time_print stays 3, resumes same phase.
//  6 start with mode=3 -> stays MENU; restart+start same cycle in OVER -> MENU, outputs cleared.

Source files
------------

// File: rtl/game_status_ctrl_if.sv
// Control pulses from the debouncers and status outputs to the HUD renderer.
interface game_status_ctrl_if;
    logic [2:0] mode;
    logic       start;
    logic       hit;
    logic       pause;
    logic       restart;
    logic       enable_game_classic;
    logic       enable_game_infinity;
    logic       enable_information;
    logic [4:0] HP_print;
    logic [4:0] time_print;
    logic       game_over;

    modport master (
        output mode, start, hit, pause, restart,
        input  enable_game_classic, enable_game_infinity, enable_information,
        input  HP_print, time_print, game_over
    );

    modport slave (
        input  mode, start, hit, pause, restart,
        output enable_game_classic, enable_game_infinity, enable_information,
        output HP_print, time_print, game_over
    );
endinterface

// File: rtl/game_status_ctrl.sv
// Game-session sequencer for the HUD bar: MENU/PLAY/PAUSE/OVER with hit counting
// (classic) or elapsed-step counting (infinity); every output comes from a flop.
module game_status_ctrl #(
    parameter int unsigned TICK_DIV     = 100_000_000,
    parameter int unsigned HP_MAX       = 9,
    parameter int unsigned TIME_MAX     = 18,
    parameter int unsigned GUARD_CYCLES = 50_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    game_status_ctrl_if.slave   bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int unsigned CW = 5;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] HP_LAST    = CW'(HP_MAX);
    localparam logic [CW-1:0] TIME_LAST  = CW'(TIME_MAX);
    localparam logic [2:0]    MODE_C     = 3'd1;
    localparam logic [2:0]    MODE_I     = 3'd2;
    localparam logic          SESS_C     = 1'b0;
    localparam logic          SESS_I     = 1'b1;

    typedef enum logic [2:0] {
        MENU   = 3'd0,
        PLAY_C = 3'd1,
        PLAY_I = 3'd2,
        PAUSE  = 3'd3,
        OVER   = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic           sess_mode, sess_nxt;
    logic [CW-1:0]  hp_q, hp_nxt, hp_inc;
    logic [CW-1:0]  tm_q, tm_nxt, tm_inc;
    logic [PW-1:0]  presc_q, presc_nxt;
    logic [GW-1:0]  guard_q, guard_nxt;

    logic en_c_q, en_i_q, info_q, over_q;
    logic en_c_nxt, en_i_nxt, info_nxt, over_nxt;

    assign hp_inc = hp_q + CW'(1);
    assign tm_inc = tm_q + CW'(1);

    // State, session counters and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MENU;
            sess_mode <= SESS_C;
            hp_q      <= '0;
            tm_q      <= '0;
            presc_q   <= '0;
            guard_q   <= '0;
            en_c_q    <= 1'b0;
            en_i_q    <= 1'b0;
            info_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sess_mode <= sess_nxt;
            hp_q      <= hp_nxt;
            tm_q      <= tm_nxt;
            presc_q   <= presc_nxt;
            guard_q   <= guard_nxt;
            en_c_q    <= en_c_nxt;
            en_i_q    <= en_i_nxt;
            info_q    <= info_nxt;
            over_q    <= over_nxt;
        end
    end

    // Next state and counter updates; restart outranks everything else
    always_comb begin
        state_nxt = state;
        sess_nxt  = sess_mode;
        hp_nxt    = hp_q;
        tm_nxt    = tm_q;
        presc_nxt = presc_q;
        guard_nxt = guard_q;

        if (bus.restart) begin
            state_nxt = MENU;
            hp_nxt    = '0;
            tm_nxt    = '0;
            presc_nxt = '0;
            guard_nxt = '0;
        end else begin
            case (state)
                MENU: begin
                    if (bus.start && (bus.mode == MODE_C || bus.mode == MODE_I)) begin
                        state_nxt = (bus.mode == MODE_C) ? PLAY_C : PLAY_I;
                        sess_nxt  = (bus.mode == MODE_C) ? SESS_C : SESS_I;
                        hp_nxt    = '0;
                        tm_nxt    = '0;
                        presc_nxt = '0;
                        guard_nxt = '0;
                    end
                end
                PLAY_C: begin
                    // Pause freezes the guard too, so a hit on the same cycle is simply lost
                    if (bus.pause) begin
                        state_nxt = PAUSE;
                    end else if (guard_q != '0) begin
                        guard_nxt = guard_q - GW'(1);
                    end else if (bus.hit && hp_q < HP_LAST) begin
                        hp_nxt    = hp_inc;
                        guard_nxt = GUARD_LOAD;
                        if (hp_inc == HP_LAST) begin
                            state_nxt = OVER;
                        end
                    end
                end
                PLAY_I: begin
                    if (bus.pause) begin
                        state_nxt = PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_nxt = '0;
                        if (tm_q < TIME_LAST) begin
                            tm_nxt = tm_inc;
                            if (tm_inc == TIME_LAST) begin
                                state_nxt = OVER;
                            end
                        end
                    end else begin
                        presc_nxt = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (bus.pause) begin
                        state_nxt = (sess_mode == SESS_I) ? PLAY_I : PLAY_C;
                    end
                end
                OVER: begin
                    state_nxt = OVER;
                end
                default: begin
                    state_nxt = MENU;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the flops track it with one-cycle latency
    always_comb begin
        en_c_nxt = 1'b0;
        en_i_nxt = 1'b0;
        info_nxt = 1'b0;
        over_nxt = (state_nxt == OVER);
        if (state_nxt != MENU) begin
            info_nxt = 1'b1;
            en_c_nxt = (sess_nxt == SESS_C);
            en_i_nxt = (sess_nxt == SESS_I);
        end
    end

    assign bus.enable_game_classic  = en_c_q;
    assign bus.enable_game_infinity = en_i_q;
    assign bus.enable_information   = info_q;
    assign bus.HP_print             = hp_q;
    assign bus.time_print           = tm_q;
    assign bus.game_over            = over_q;
endmodule

// File: tb/tb_game_status_ctrl.sv
// Scoreboard bench for game_status_ctrl with a shortened tick and guard window.
module tb_game_status_ctrl;
    typedef struct packed {
        logic       en_c;
        logic       en_i;
        logic       info;
        logic [4:0] hp;
        logic [4:0] tm;
        logic       over;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    obs_t exp_q[$];

    game_status_ctrl_if dif();

    game_status_ctrl #(
        .TICK_DIV     (4),
        .HP_MAX       (9),
        .TIME_MAX     (18),
        .GUARD_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    // k: 0 menu, 1 classic active, 2 infinity active, 3 classic over, 4 infinity over
    function automatic obs_t ex(input int k, input int hp, input int tm);
        obs_t e;
        e.en_c = (k == 1 || k == 3);
        e.en_i = (k == 2 || k == 4);
        e.info = (k != 0);
        e.hp   = 5'(hp);
        e.tm   = 5'(tm);
        e.over = (k >= 3);
        return e;
    endfunction

    function automatic obs_t obs_now();
        obs_t o;
        o.en_c = dif.enable_game_classic;
        o.en_i = dif.enable_game_infinity;
        o.info = dif.enable_information;
        o.hp   = dif.HP_print;
        o.tm   = dif.time_print;
        o.over = dif.game_over;
        return o;
    endfunction

    // One clocked cycle of stimulus; the expected post-edge view goes on the scoreboard
    task automatic drive(input logic s, input logic h, input logic p, input logic r,
                         input logic [2:0] m, input obs_t e);
        dif.start   = s;
        dif.hit     = h;
        dif.pause   = p;
        dif.restart = r;
        dif.mode    = m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        dif.start   = 1'b0;
        dif.hit     = 1'b0;
        dif.pause   = 1'b0;
        dif.restart = 1'b0;
        dif.mode    = 3'd0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst_n = 1'b0;
        wait_cycles(2);
        exp_q.push_back(ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_init got %h want %h", o, e); end
        rst_n = 1'b1;
        wait_cycles(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, ex(1, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_start got %h want %h", o, e); end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex(1, i, 0));
            e = exp_q.pop_front(); o = obs_now(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL reset_hit%0d got %h want %h", i, o, e); end
            wait_cycles(3);
        end
        // Asynchronous assertion: outputs must drop between clock edges
        rst_n = 1'b0;
        #2;
        exp_q.push_back(ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_async got %h want %h", o, e); end
        wait_cycles(1);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_menu got %h want %h", o, e); end
    endtask

    task automatic test_classic_hits();
        obs_t e, o;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, ex(1, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL classic_start got %h want %h", o, e); end
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex((i == 9) ? 3 : 1, i, 0));
            e = exp_q.pop_front(); o = obs_now(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL classic_hit%0d got %h want %h", i, o, e); end
            wait_cycles(3);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex(3, 9, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL classic_hit10 got %h want %h", o, e); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, ex(3, 9, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL over_pause got %h want %h", o, e); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, ex(3, 9, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL over_start got %h want %h", o, e); end
    endtask

    task automatic test_guard();
        obs_t e, o;
        int   want_hp[4] = '{1, 1, 1, 2};
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL guard_restart got %h want %h", o, e); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, ex(1, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL guard_start got %h want %h", o, e); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex(1, want_hp[i], 0));
            e = exp_q.pop_front(); o = obs_now(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL guard_hit_c%0d got %h want %h", i, o, e); end
        end
        // pause and hit together: pause wins
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, ex(1, 2, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pause_hit got %h want %h", o, e); end
        wait_cycles(4);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex(1, 2, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL paused_hit got %h want %h", o, e); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, ex(1, 2, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL unpause_c got %h want %h", o, e); end
        wait_cycles(3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex(1, 3, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL resume_hit got %h want %h", o, e); end
    endtask

    task automatic test_infinity();
        obs_t e, o;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL inf_restart got %h want %h", o, e); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, ex(2, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL inf_start got %h want %h", o, e); end
        for (int n = 1; n <= 72; n++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, ex((n == 72) ? 4 : 2, 0, n / 4));
            e = exp_q.pop_front(); o = obs_now(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL inf_cycle%0d got %h want %h", n, o, e); end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex(4, 0, 18));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL inf_over_hit got %h want %h", o, e); end
        wait_cycles(8);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, ex(4, 0, 18));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL inf_saturate got %h want %h", o, e); end
    endtask

    task automatic test_pause_inf();
        obs_t e, o;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pinf_restart got %h want %h", o, e); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, ex(2, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pinf_start got %h want %h", o, e); end
        wait_cycles(14);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, ex(2, 0, 3));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pinf_pause got %h want %h", o, e); end
        for (int n = 0; n < 20; n++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex(2, 0, 3));
            e = exp_q.pop_front(); o = obs_now(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL pinf_hold%0d got %h want %h", n, o, e); end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, ex(2, 0, 3));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pinf_resume got %h want %h", o, e); end
        // Prescaler resumes at phase 2, so one edge stays at 3 and the next steps to 4
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, ex(2, 0, 3));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pinf_phase_a got %h want %h", o, e); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, ex(2, 0, 4));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL pinf_phase_b got %h want %h", o, e); end
    endtask

    task automatic test_menu_and_restart();
        obs_t e, o;
        logic [2:0] bad_modes[4] = '{3'd3, 3'd0, 3'd7, 3'd4};
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL mr_restart got %h want %h", o, e); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, bad_modes[i], ex(0, 0, 0));
            e = exp_q.pop_front(); o = obs_now(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL bad_mode%0d got %h want %h", i, o, e); end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, ex(1, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL mr_start got %h want %h", o, e); end
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, ex((i == 9) ? 3 : 1, i, 0));
            e = exp_q.pop_front(); o = obs_now(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL mr_hit%0d got %h want %h", i, o, e); end
            wait_cycles(3);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL restart_start got %h want %h", o, e); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, ex(0, 0, 0));
        e = exp_q.pop_front(); o = obs_now(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL menu_hold got %h want %h", o, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        dif.start   = 1'b0;
        dif.hit     = 1'b0;
        dif.pause   = 1'b0;
        dif.restart = 1'b0;
        dif.mode    = 3'd0;
        test_reset();
        test_classic_hits();
        test_guard();
        test_infinity();
        test_pause_inf();
        test_menu_and_restart();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
